// File: rtl/operacao_logica_serial.sv
// Serial multi-function bitwise logic unit (XOR/AND/OR/XNOR), SLICE bits per clock,
// LSB slice first, with start/busy/done handshake and registered zero/parity flags.
module operacao_logica_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
);

  localparam int unsigned NSLICES = WIDTH / SLICE;
  localparam int unsigned CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_next;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic [SLICE-1:0] slice_res;
  logic             last_slice;
  logic             capture;
  logic             busy_d, done_d;

  function automatic logic [SLICE-1:0] slice_op(input logic [1:0] o,
                                                input logic [SLICE-1:0] sx,
                                                input logic [SLICE-1:0] sy);
    logic [SLICE-1:0] r;
    r = '0;
    case (o)
      2'b00:   r = sx ^ sy;
      2'b01:   r = sx & sy;
      2'b10:   r = sx | sy;
      default: r = ~(sx ^ sy);
    endcase
    return r;
  endfunction

  // Operands shift right each cycle; finished slices enter the accumulator from the top
  assign slice_res  = slice_op(op_q, a_q[SLICE-1:0], b_q[SLICE-1:0]);
  assign acc_next   = (acc >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));
  assign last_slice = (cnt == LAST_CNT);
  assign capture    = start && ((state == IDLE) || (state == DONE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the upcoming state, then registered
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_next)
      RUN:     busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
    end
  end

  // Datapath: operand capture, slice processing and result commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      cnt    <= '0;
      acc    <= '0;
      y      <= '0;
      zero   <= 1'b1;
      parity <= 1'b0;
    end else if (capture) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
      cnt  <= '0;
      acc  <= '0;
    end else if (state == RUN) begin
      a_q <= a_q >> SLICE;
      b_q <= b_q >> SLICE;
      cnt <= cnt + CNT_W'(1);
      acc <= acc_next;
      if (last_slice) begin
        y      <= acc_next;
        zero   <= (acc_next == '0);
        parity <= ^acc_next;
      end
    end
  end

endmodule

// File: tb/tb_operacao_logica_serial.sv
// Self-checking bench for operacao_logica_serial: default 8/4, 16/4 and 8/8 instances.
module tb_operacao_logica_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start_w, start_s;
  logic [1:0]  op;
  logic [15:0] a, b;

  logic        busy_a, done_a, zero_a, par_a;
  logic [7:0]  y_a;
  logic        busy_w, done_w, zero_w, par_w;
  logic [15:0] y_w;
  logic        busy_s, done_s, zero_s, par_s;
  logic [7:0]  y_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operacao_logica_serial #(.WIDTH(8), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a[7:0]), .b(b[7:0]),
    .busy(busy_a), .done(done_a), .y(y_a), .zero(zero_a), .parity(par_a));

  operacao_logica_serial #(.WIDTH(16), .SLICE(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .op(op), .a(a), .b(b),
    .busy(busy_w), .done(done_w), .y(y_w), .zero(zero_w), .parity(par_w));

  operacao_logica_serial #(.WIDTH(8), .SLICE(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .op(op), .a(a[7:0]), .b(b[7:0]),
    .busy(busy_s), .done(done_s), .y(y_s), .zero(zero_s), .parity(par_s));

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       zero;
    logic       parity;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge; sample/drive 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation on instance 'which' (0: 8/4, 1: 16/4, 2: 8/8) and check latency
  task automatic run_op(input int which, input logic [1:0] o, input logic [15:0] aa,
                        input logic [15:0] bb, input int exp_lat, output logic [15:0] yy);
    int lat;
    logic dn, bz;
    op = o; a = aa; b = bb;
    case (which)
      0: start = 1'b1;
      1: start_w = 1'b1;
      default: start_s = 1'b1;
    endcase
    tick();
    start = 1'b0; start_w = 1'b0; start_s = 1'b0;
    bz = (which == 0) ? busy_a : (which == 1) ? busy_w : busy_s;
    chk("busy_after_start", 32'(bz), 32'd1);
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      dn = (which == 0) ? done_a : (which == 1) ? done_w : done_s;
      if (dn) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, exp_lat);
    yy = (which == 0) ? {8'h00, y_a} : (which == 1) ? y_w : {8'h00, y_s};
  endtask

  initial begin
    logic [15:0] yy;

    vecs[0] = '{2'b00, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0};
    vecs[1] = '{2'b00, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0};
    vecs[2] = '{2'b01, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vecs[3] = '{2'b10, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0};
    vecs[4] = '{2'b11, 8'hF0, 8'h3C, 8'h33, 1'b0, 1'b0};
    vecs[5] = '{2'b00, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{2'b10, 8'h01, 8'h00, 8'h01, 1'b0, 1'b1};
    vecs[7] = '{2'b01, 8'hFF, 8'h81, 8'h81, 1'b0, 1'b0};
    vecs[8] = '{2'b11, 8'h00, 8'h07, 8'hF8, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; start_w = 1'b0; start_s = 1'b0;
    op = 2'b00; a = '0; b = '0;
    repeat (3) tick();
    chk("rst_y", 32'(y_a), 32'h0);
    chk("rst_zero", 32'(zero_a), 32'd1);
    chk("rst_parity", 32'(par_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_quiet", 32'({busy_a, done_a, zero_a}), 32'b001);
    end

    // Table-driven functional vectors on the default instance
    foreach (vecs[i]) begin
      run_op(0, vecs[i].op, 16'(vecs[i].a), 16'(vecs[i].b), 2, yy);
      chk("vec_y", 32'(yy), 32'(vecs[i].y));
      chk("vec_zero", 32'(zero_a), 32'(vecs[i].zero));
      chk("vec_parity", 32'(par_a), 32'(vecs[i].parity));
      chk("vec_busy_in_done", 32'(busy_a), 32'd0);
      tick();
      chk("vec_done_pulse", 32'(done_a), 32'd0);
      chk("vec_y_hold", 32'(y_a), 32'(vecs[i].y));
    end

    // Operand isolation: inputs change and start pulses mid-RUN
    op = 2'b01; a = 16'h00F0; b = 16'h003C; start = 1'b1;
    tick();
    op = 2'b10; a = 16'h00FF; b = 16'h00FF;
    tick();
    start = 1'b0;
    chk("iso_no_early_done", 32'(done_a), 32'd0);
    chk("iso_y_not_partial", 32'(y_a), 32'hF8);
    tick();
    chk("iso_done", 32'(done_a), 32'd1);
    chk("iso_y", 32'(y_a), 32'h30);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("iso_no_extra_op", 32'({busy_a, done_a}), 32'b00);
    end
    chk("iso_y_hold", 32'(y_a), 32'h30);

    // Back-to-back: start held through DONE
    op = 2'b00; a = 16'h00A5; b = 16'h000F; start = 1'b1;
    tick();
    tick();
    tick();
    chk("b2b_done1", 32'(done_a), 32'd1);
    chk("b2b_y1", 32'(y_a), 32'hAA);
    op = 2'b10; a = 16'h00F0; b = 16'h003C;
    tick();
    start = 1'b0;
    chk("b2b_rerun_busy", 32'({busy_a, done_a}), 32'b10);
    tick();
    chk("b2b_mid", 32'(done_a), 32'd0);
    tick();
    chk("b2b_done2", 32'(done_a), 32'd1);
    chk("b2b_y2", 32'(y_a), 32'hFC);

    // Reset mid-RUN aborts without a done pulse
    tick();
    op = 2'b00; a = 16'h005A; b = 16'h00A5; start = 1'b1;
    tick();
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_y", 32'(y_a), 32'h0);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_zero", 32'(zero_a), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_done", 32'({busy_a, done_a}), 32'b00);
    end
    chk("abort_y_after", 32'(y_a), 32'h0);

    // Wider and single-slice instances
    run_op(1, 2'b00, 16'h1234, 16'hFFFF, 4, yy);
    chk("w16_y", 32'(yy), 32'hEDCB);
    chk("w16_zero", 32'(zero_w), 32'd0);
    chk("w16_parity", 32'(par_w), 32'd1);
    tick();
    chk("w16_done_pulse", 32'(done_w), 32'd0);

    run_op(2, 2'b00, 16'h00A5, 16'h000F, 1, yy);
    chk("s8_y", 32'(yy), 32'hAA);
    chk("s8_parity", 32'(par_s), 32'd0);
    tick();
    chk("s8_done_pulse", 32'(done_s), 32'd0);
    run_op(2, 2'b01, 16'h00F0, 16'h003C, 1, yy);
    chk("s8_and_y", 32'(yy), 32'h30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operacao_logica_serial.md
Name: operacao_logica_serial

Overview:
Parametrised successor to the fixed 8-bit XOR unit: a multi-function bitwise logic unit (XOR, AND, OR, XNOR) of configurable width. It processes its operands SLICE bits per clock, LSB slice first, under a start/busy/done handshake, then presents a registered result with zero and parity flags. It sits in the ALU datapath beside the arithmetic units, selected by the control FSM.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of SLICE; WIDTH >= SLICE.
SLICE, 4, bits processed per clock cycle.
NSLICES, WIDTH/SLICE (derived, localparam), number of processing cycles per operation.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE or DONE.
op  input  2  operation: 00 XOR, 01 AND, 10 OR, 11 XNOR; captured with start.
a  input  WIDTH  operand A; captured with start.
b  input  WIDTH  operand B; captured with start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse: y, zero and parity are newly valid.
y  output  WIDTH  registered result; held until the next completion.
zero  output  1  registered, (y == 0).
parity  output  1  registered, XOR-reduction of y (1 = odd number of ones).

Behaviour:
- Reset (rst_n low, asynchronous, any state): state IDLE; busy=0, done=0, y=0, zero=1, parity=0; slice counter, captured operands/op and accumulator cleared. Deassertion has no effect until the next rising edge.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge k -> capture a, b, op into internal registers; counter=0; go RUN. start=0 -> stay.
- RUN: busy=1. At each edge, compute slice [cnt*SLICE +: SLICE] of captured a op captured b into the accumulator; increment cnt. Edges k+1 .. k+NSLICES process slices 0 .. NSLICES-1. At edge k+NSLICES (last slice): load y with the full accumulated result (including that last slice), update zero/parity from the new y, go DONE.
- start, a, b and op are ignored during RUN; operand changes after capture do not affect the result.
- DONE: exactly one cycle; done=1, busy=0. start=1 in DONE is accepted exactly as in IDLE (captures, goes RUN), allowing back-to-back operations with no idle gap; otherwise go IDLE.
- Latency: done high in the cycle following edge k+NSLICES, i.e. NSLICES cycles after the start edge (2 for defaults). Throughput: one result per NSLICES+1 cycles.
- y/zero/parity change only on the completion edge; intermediate slice results are never visible on y.
- NSLICES=1 (WIDTH==SLICE): RUN lasts one cycle; same state sequence.
- Reset asserted mid-RUN aborts the operation: no done pulse; y returns to 0.

Test Plan:
- Reset then idle: rst_n low -> y=0, zero=1, parity=0, busy=0, done=0; no activity with start=0 for 10 cycles.
- XOR default width: a=8'hA5, b=8'h0F, op=00, start 1 cycle -> busy for 2 cycles, then done pulse with y=8'hAA, zero=0, parity=0; y holds 8'hAA afterwards.
- All ops, a=8'hF0, b=8'h3C: XOR->8'hCC, AND->8'h30, OR->8'hFC, XNOR->8'h33; XOR of a=b=8'h5A -> y=0, zero=1, parity=0; a=8'h01, b=0, OR -> parity=1.
- Operand isolation and ignored start: change a/b/op and pulse start during RUN -> result equals captured operands, no extra operation, single done pulse.
- Back-to-back: start held high across DONE with new operands -> second operation begins in the DONE cycle, done pulses every 3 cycles with correct results.
- Reset mid-operation and parametrisation: assert rst_n during RUN -> no done, y=0, IDLE; rerun with WIDTH=16, SLICE=4 (a=16'h1234, b=16'hFFFF, XOR -> 16'hEDCB, done 4 cycles after start) and WIDTH=SLICE=8 (done 1 cycle after start).
